// File: rtl/bar_pkg.sv
// ============================================================================
// Module      : bar_pkg
// Description : Shared PS/2 codes, key-tracker and direction encodings, and
//               640x480 screen constants for the paddle bar blocks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bar_pkg;

    localparam logic [7:0] C_BREAK_CODE = 8'hF0;
    localparam logic [7:0] C_EXT_CODE   = 8'hE0;

    localparam int C_H_DISPLAY = 640;
    localparam int C_V_DISPLAY = 480;

    typedef enum logic [0:0] {
        K_IDLE  = 1'b0,
        K_BREAK = 1'b1
    } key_state_e;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DOWN = 2'd2
    } dir_e;

    // Next speed after a move of size v, capped at vmax.
    function automatic logic [3:0] vel_step_up(input logic [3:0] v,
                                               input logic [3:0] vmax);
        if (v >= vmax)
            return vmax;
        else
            return v + 4'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_key_tracker.sv
// ============================================================================
// Module      : ps2_key_tracker
// Description : Tracks held state of an up and a down key from a PS/2 set-2
//               scan-code byte stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_key_tracker
    import bar_pkg::*;
#(
    parameter logic [7:0] KEY_UP   = 8'h1D,
    parameter logic [7:0] KEY_DOWN = 8'h1B
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [7:0] key_code,
    output logic       up_held,
    output logic       down_held
);

    key_state_e r_state;
    key_state_e w_state_next;
    logic       r_up_held;
    logic       r_down_held;
    logic       w_up_next;
    logic       w_down_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= K_IDLE;
            r_up_held   <= 1'b0;
            r_down_held <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_up_held   <= w_up_next;
            r_down_held <= w_down_next;
        end
    end

    // The extended prefix carries no meaning for these keys and is skipped.
    always_comb begin
        w_state_next = r_state;
        w_up_next    = r_up_held;
        w_down_next  = r_down_held;
        if (key_valid && (key_code != C_EXT_CODE)) begin
            case (r_state)
                K_IDLE: begin
                    if (key_code == C_BREAK_CODE)
                        w_state_next = K_BREAK;
                    else if (key_code == KEY_UP)
                        w_up_next = 1'b1;
                    else if (key_code == KEY_DOWN)
                        w_down_next = 1'b1;
                end
                K_BREAK: begin
                    if (key_code == KEY_UP)
                        w_up_next = 1'b0;
                    else if (key_code == KEY_DOWN)
                        w_down_next = 1'b0;
                    w_state_next = K_IDLE;
                end
                default: w_state_next = K_IDLE;
            endcase
        end
    end

    assign up_held   = r_up_held;
    assign down_held = r_down_held;

endmodule

`default_nettype wire

// File: rtl/bar_mover.sv
// ============================================================================
// Module      : bar_mover
// Description : Keyboard-driven vertical paddle bar; moves once per frame tick
//               with optional acceleration and renders a registered pixel hit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bar_mover
    import bar_pkg::*;
#(
    parameter int         LEFT_X    = 600,
    parameter int         BAR_W     = 6,
    parameter int         BAR_H     = 72,
    parameter int         V_DISPLAY = 480,
    parameter int         START_Y   = 0,
    parameter int         VEL_MIN   = 4,
    parameter int         VEL_MAX   = 4,
    parameter int         ACCEL     = 0,
    parameter logic [7:0] KEY_UP    = 8'h1D,
    parameter logic [7:0] KEY_DOWN  = 8'h1B,
    parameter int         FRAME_Y   = 481
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [7:0] key_code,
    input  logic [9:0] xCount,
    input  logic [9:0] yCount,
    input  logic       mask,
    output logic       draw_bar,
    output logic [9:0] bar_top,
    output logic [3:0] bar_vel
);

    localparam logic [10:0] C_BOTTOM  = 11'(V_DISPLAY - BAR_H);
    localparam logic [10:0] C_LEFT    = 11'(LEFT_X);
    localparam logic [10:0] C_RIGHT   = 11'(LEFT_X + BAR_W);
    localparam logic [10:0] C_BAR_H   = 11'(BAR_H);
    localparam logic [9:0]  C_FRAME_Y = 10'(FRAME_Y);
    localparam logic [9:0]  C_START_Y = 10'(START_Y);
    localparam logic [3:0]  C_VEL_MIN = 4'(VEL_MIN);
    localparam logic [3:0]  C_VEL_MAX = 4'(VEL_MAX);

    logic        w_up_held;
    logic        w_down_held;
    logic        w_tick;
    dir_e        w_dir;
    dir_e        r_last_dir;
    logic [3:0]  r_vel;
    logic [3:0]  w_step;
    logic [3:0]  w_vel_next;
    logic [9:0]  r_bar_top;
    logic [10:0] w_top_ext;
    logic [10:0] w_step_ext;
    logic [10:0] w_sum;
    logic [10:0] w_top_moved;
    logic [10:0] w_x;
    logic [10:0] w_y;
    logic        w_hit;
    logic        r_draw;

    ps2_key_tracker #(
        .KEY_UP   (KEY_UP),
        .KEY_DOWN (KEY_DOWN)
    ) u_key_tracker (
        .clk       (clk),
        .reset     (reset),
        .key_valid (key_valid),
        .key_code  (key_code),
        .up_held   (w_up_held),
        .down_held (w_down_held)
    );

    assign w_tick = (yCount == C_FRAME_Y) && (xCount == 10'd0);

    always_comb begin
        w_dir = DIR_NONE;
        if (w_up_held && !w_down_held)
            w_dir = DIR_UP;
        else if (w_down_held && !w_up_held)
            w_dir = DIR_DOWN;
    end

    // A fresh direction always starts at the minimum step; speed then builds.
    always_comb begin
        w_step     = C_VEL_MIN;
        w_vel_next = C_VEL_MIN;
        if ((ACCEL != 0) && (w_dir == r_last_dir))
            w_step = r_vel;
        if ((ACCEL != 0) && (w_dir != DIR_NONE))
            w_vel_next = vel_step_up(w_step, C_VEL_MAX);
    end

    assign w_top_ext  = {1'b0, r_bar_top};
    assign w_step_ext = {7'd0, w_step};
    assign w_sum      = w_top_ext + w_step_ext;

    always_comb begin
        w_top_moved = w_top_ext;
        case (w_dir)
            DIR_DOWN: w_top_moved = (w_sum > C_BOTTOM) ? C_BOTTOM : w_sum;
            DIR_UP:   w_top_moved = (w_top_ext < w_step_ext) ? 11'd0
                                                             : (w_top_ext - w_step_ext);
            default:  w_top_moved = w_top_ext;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bar_top  <= C_START_Y;
            r_vel      <= C_VEL_MIN;
            r_last_dir <= DIR_NONE;
        end else if (w_tick) begin
            r_bar_top  <= w_top_moved[9:0];
            r_vel      <= w_vel_next;
            r_last_dir <= w_dir;
        end
    end

    assign w_x   = {1'b0, xCount};
    assign w_y   = {1'b0, yCount};
    assign w_hit = (w_x >= C_LEFT) && (w_x < C_RIGHT) &&
                   (w_y >= w_top_ext) && (w_y < (w_top_ext + C_BAR_H)) && !mask;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_draw <= 1'b0;
        else
            r_draw <= w_hit;
    end

    assign draw_bar = r_draw;
    assign bar_top  = r_bar_top;
    assign bar_vel  = r_vel;

endmodule

`default_nettype wire

// File: tb/tb_bar_mover.sv
// ============================================================================
// Module      : tb_bar_mover
// Description : Self-checking bench for bar_mover: three parameterisations
//               share one stimulus stream and are compared to a frame model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bar_mover;

    logic       clk = 1'b0;
    logic       reset;
    logic       key_valid;
    logic [7:0] key_code;
    logic [9:0] xCount;
    logic [9:0] yCount;
    logic       mask;
    logic       draw[3];
    logic [9:0] top[3];
    logic [3:0] vel[3];

    int p_start[3] = '{0, 406, 0};
    int p_vmin[3]  = '{4, 4, 1};
    int p_vmax[3]  = '{4, 4, 4};
    int p_acc[3]   = '{0, 0, 1};

    int m_top[3];
    int m_vel[3];
    int m_last[3];
    bit m_up, m_down, m_brk;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    bar_mover #(.START_Y(0)) u_dut0 (
        .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
        .xCount(xCount), .yCount(yCount), .mask(mask),
        .draw_bar(draw[0]), .bar_top(top[0]), .bar_vel(vel[0])
    );

    bar_mover #(.START_Y(406)) u_dut1 (
        .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
        .xCount(xCount), .yCount(yCount), .mask(mask),
        .draw_bar(draw[1]), .bar_top(top[1]), .bar_vel(vel[1])
    );

    bar_mover #(.ACCEL(1), .VEL_MIN(1), .VEL_MAX(4)) u_dut2 (
        .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
        .xCount(xCount), .yCount(yCount), .mask(mask),
        .draw_bar(draw[2]), .bar_top(top[2]), .bar_vel(vel[2])
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s top%0d", tag, i), 16'(top[i]), 16'(m_top[i]));
            check($sformatf("%s vel%0d", tag, i), 16'(vel[i]), 16'(m_vel[i]));
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            m_top[i]  = p_start[i];
            m_vel[i]  = p_vmin[i];
            m_last[i] = 0;
        end
        m_up = 0; m_down = 0; m_brk = 0;
    endfunction

    function automatic void model_key(input logic [7:0] code);
        if (code == 8'hE0) return;
        if (m_brk) begin
            if (code == 8'h1D) m_up = 0;
            else if (code == 8'h1B) m_down = 0;
            m_brk = 0;
        end else if (code == 8'hF0) m_brk = 1;
        else if (code == 8'h1D) m_up = 1;
        else if (code == 8'h1B) m_down = 1;
    endfunction

    // One frame: direction +1 = down the screen, -1 = up, 0 = stay.
    function automatic void model_tick();
        int dir;
        int step;
        dir = (m_up && !m_down) ? -1 : ((m_down && !m_up) ? 1 : 0);
        for (int i = 0; i < 3; i++) begin
            if (dir == 0) begin
                m_vel[i]  = p_vmin[i];
                m_last[i] = 0;
            end else begin
                step = (p_acc[i] != 0 && dir == m_last[i]) ? m_vel[i] : p_vmin[i];
                m_vel[i] = (p_acc[i] != 0) ? ((step + 1 > p_vmax[i]) ? p_vmax[i] : step + 1)
                                           : p_vmin[i];
                m_last[i] = dir;
                m_top[i] = m_top[i] + dir * step;
                if (m_top[i] < 0) m_top[i] = 0;
                if (m_top[i] > 480 - 72) m_top[i] = 480 - 72;
            end
        end
    endfunction

    task automatic do_key(input logic [7:0] code);
        key_valid = 1'b1;
        key_code  = code;
        @(posedge clk); #1;
        key_valid = 1'b0;
        model_key(code);
    endtask

    task automatic do_tick(input string tag);
        yCount = 10'd481; xCount = 10'd0;
        @(posedge clk); #1;
        yCount = 10'd0; xCount = 10'd5;
        model_tick();
        check_all(tag);
    endtask

    task automatic do_tick_key(input string tag, input logic [7:0] code);
        yCount = 10'd481; xCount = 10'd0;
        key_valid = 1'b1; key_code = code;
        @(posedge clk); #1;
        yCount = 10'd0; xCount = 10'd5; key_valid = 1'b0;
        model_tick();
        model_key(code);
        check_all(tag);
    endtask

    task automatic probe(input string tag, input int x, input int y, input bit mk);
        bit exp;
        xCount = 10'(x); yCount = 10'(y); mask = mk;
        @(posedge clk); #1;
        xCount = 10'd5; yCount = 10'd0; mask = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp = (x >= 600) && (x < 606) && (y >= m_top[i]) && (y < m_top[i] + 72) && !mk;
            check($sformatf("%s draw%0d (%0d,%0d,m%0d)", tag, i, x, y, mk),
                  16'(draw[i]), 16'(exp));
        end
    endtask

    function automatic logic [7:0] pick_code();
        case ($urandom_range(0, 4))
            0: return 8'h1D;
            1: return 8'h1B;
            2: return 8'hF0;
            3: return m_brk ? 8'h1C : 8'hE0;
            default: return 8'h1C;
        endcase
    endfunction

    initial begin
        reset = 1'b1; key_valid = 1'b0; key_code = 8'h00;
        xCount = 10'd5; yCount = 10'd0; mask = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        for (int i = 0; i < 3; i++)
            check($sformatf("reset draw%0d", i), 16'(draw[i]), 16'd0);
        reset = 1'b0;

        // Constant-speed descent, then release stops motion.
        do_key(8'h1B);
        do_tick("down1");
        do_tick("down2");
        do_tick("down3");
        check("const top after 3", 16'(top[0]), 16'd12);
        check("clamp bottom", 16'(top[1]), 16'd408);
        do_key(8'hF0); do_key(8'h1B);
        do_tick("released1");
        do_tick("released2");
        do_key(8'h1D);
        do_tick("up1");
        check("up from bottom", 16'(top[1]), 16'd404);
        do_key(8'hF0); do_key(8'h1D);

        // Acceleration profile from a fresh reset.
        reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
        model_reset();
        do_key(8'h1B);
        for (int k = 0; k < 5; k++) do_tick($sformatf("accel%0d", k));
        check("accel top after 5", 16'(top[2]), 16'd14);
        do_key(8'hF0); do_key(8'h1B); do_key(8'h1D);
        do_tick("reverse");
        check("reverse top", 16'(top[2]), 16'd13);
        check("reverse vel", 16'(vel[2]), 16'd2);

        // Both held: no motion; key on tick cycle deferred one frame.
        do_key(8'h1B);
        do_tick("both held");
        do_key(8'hE0);
        do_key(8'hF0); do_key(8'h1D);
        do_key(8'hF0); do_key(8'h1B);
        do_tick_key("key on tick", 8'h1B);
        do_tick("after tick key");

        // Asynchronous reset mid-frame while down is held.
        #3 reset = 1'b1;
        #1;
        model_reset();
        check_all("async reset");
        for (int i = 0; i < 3; i++)
            check($sformatf("async reset draw%0d", i), 16'(draw[i]), 16'd0);
        @(posedge clk); #1; reset = 1'b0;
        do_tick("post reset1");
        do_tick("post reset2");
        do_key(8'h1B);
        for (int k = 0; k < 25; k++) do_tick($sformatf("to100_%0d", k));
        check("dut0 at 100", 16'(top[0]), 16'd100);

        probe("px", 600, 100, 1'b0);
        probe("px", 605, 171, 1'b0);
        probe("px", 606, 100, 1'b0);
        probe("px", 600, 172, 1'b0);
        probe("px", 600, 100, 1'b1);
        probe("px", 599, 120, 1'b0);
        probe("px", 602, 99, 1'b0);

        // Randomized mix of keys, ticks and pixel probes.
        for (int it = 0; it < 400; it++) begin
            int sel;
            int y;
            sel = $urandom_range(0, 9);
            if (sel <= 2) begin
                do_key(pick_code());
            end else if (sel <= 5) begin
                do_tick("rnd tick");
            end else if (sel == 6) begin
                do_tick_key("rnd tick+key", pick_code());
            end else begin
                y = m_top[$urandom_range(0, 2)] + $urandom_range(0, 80) - 4;
                if (y < 0) y = 0;
                if (y > 479) y = 479;
                probe("rnd", $urandom_range(596, 609), y, $urandom_range(0, 3) == 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bar_mover.md
BAR_MOVER -- requirements
Module: bar_mover

Interface
REQ-001 Parameter LEFT_X, default 600: x of the bar's left edge.
REQ-002 Parameter BAR_W, default 6: bar width in pixels.
REQ-003 Parameter BAR_H, default 72: bar height in pixels.
REQ-004 Parameter V_DISPLAY, default 480: visible lines.
REQ-005 Parameter START_Y, default 0: bar top after reset.
REQ-006 Parameter VEL_MIN, default 4: step size per frame, and the start speed in accel mode.
REQ-007 Parameter VEL_MAX, default 4: speed ceiling in accel mode; VEL_MAX >= VEL_MIN.
REQ-008 Parameter ACCEL, default 0: 0 = constant speed, 1 = accelerating speed.
REQ-009 Parameter KEY_UP, default 8'h1D; KEY_DOWN, default 8'h1B: PS/2 set-2 make codes.
REQ-010 Parameter FRAME_Y, default 481: the frame tick fires when yCount==FRAME_Y && xCount==0.
REQ-011 clk  in  1  pixel clock; the only clock.
REQ-012 reset  in  1  asynchronous, active-high.
REQ-013 key_valid  in  1  one-cycle strobe; key_code is valid on this cycle.
REQ-014 key_code  in  8  PS/2 scan code byte.
REQ-015 xCount  in  10  current pixel column.
REQ-016 yCount  in  10  current pixel line.
REQ-017 mask  in  1  when 1, suppresses draw_bar (higher-priority wall or ball object).
REQ-018 draw_bar  out  1  current pixel belongs to the bar.
REQ-019 bar_top  out  10  registered top y of the bar.
REQ-020 bar_vel  out  4  current speed magnitude.

Function
REQ-021 The key tracker SHALL be a two-state FSM, K_IDLE and K_BREAK, that advances only on key_valid.
- K_IDLE, code 8'hF0 -> K_BREAK.
- K_IDLE, KEY_UP or KEY_DOWN -> set the matching held flag.
- K_BREAK, any byte -> clear the matching held flag if it is KEY_UP or KEY_DOWN; return to K_IDLE.
REQ-022 8'hE0 and all other codes SHALL be ignored and leave the tracker state unchanged.
REQ-023 Position and velocity SHALL update only on the frame-tick cycle, using the held flags as registered before that cycle.
- A key_valid arriving on the same cycle as the tick affects the next frame only.
REQ-024 Direction is up when only up_held is set and down when only down_held is set. Neither or both held: no move, and velocity returns to VEL_MIN.
REQ-025 ACCEL=1 behaviour:
- Each tick in the same direction as the previous tick moves by the current velocity, then increments velocity, saturating at VEL_MAX.
- A direction change moves by VEL_MIN and reloads velocity.
REQ-026 ACCEL=0: every move is exactly VEL_MIN.
REQ-027 Moving down SHALL saturate bar_top at V_DISPLAY-BAR_H; moving up SHALL saturate at 0.
- Arithmetic is 11-bit to avoid wrap-around.
- Velocity is not reset by a clamp.
REQ-028 Pixel comparison: hit = xCount in [LEFT_X, LEFT_X+BAR_W) && yCount in [bar_top, bar_top+BAR_H) && !mask.
REQ-029 draw_bar SHALL be registered: hit from cycle n appears at cycle n+1.
REQ-030 A move SHALL take effect at the next tick cycle + 1, which falls in vertical blanking, so no frame ever shows a torn bar.

Reset
REQ-031 On reset, regardless of activity in progress:
- bar_top=START_Y, bar_vel=VEL_MIN, draw_bar=0;
- both held flags cleared, tracker in K_IDLE;
- last-direction register = none.
REQ-032 Deassertion is synchronised externally; the block requires no extra delay.

Structure
REQ-033 Package bar_pkg SHALL hold the 8'hF0 and 8'hE0 code constants, the tracker state encoding, and the 640x480 screen constants.
REQ-034 The key tracker SHALL be the sub-module ps2_key_tracker (ports clk, reset, key_valid, key_code, up_held, down_held), reusable by the other player's paddle.

Verification
REQ-035 ACCEL=0, START_Y=0: key 1B, then 3 ticks -> bar_top 4, 8, 12; then F0,1B and 2 ticks -> stays 12.
REQ-036 START_Y=406, down held, 2 ticks -> bar_top 408, 408; then up held only -> 404.
REQ-037 ACCEL=1, VEL_MIN=1, VEL_MAX=4, down held, 5 ticks -> bar_top 1, 3, 6, 10, 14; switch to up -> 13, bar_vel=2.
REQ-038 bar_top=100, mask=0:
- pixel (600,100) -> draw_bar=1 one cycle later;
- (605,171) -> 1; (606,100) -> 0; (600,172) -> 0;
- (600,100) with mask=1 -> 0.
REQ-039 Both 1D and 1B held, tick -> no move, bar_vel=VEL_MIN; key_valid with 1B on the tick cycle -> no move until the following tick.
REQ-040 reset pulse mid-frame while down held at bar_top=200 -> bar_top=START_Y, draw_bar=0, no motion on later ticks until a new make code.
